// File: rtl/wb_bayer_stat_if.sv
// wb_bayer_stat_if
// Purpose : groups the video stream, pattern select, colour flags and frame
//           statistics of wb_bayer_stat into one bundle.
// Ports   : iv_pattern, i_fval, i_lval, iv_pix_data  -> into the block
//           o_fval, o_lval, ov_pix_data              <- stream delayed 1 clock
//           ov_r/g/b_flag                            <- per-lane colour tags
//           ov_r/g/b_sum, o_sum_valid, o_sum_ovf     <- per-frame statistics
// The parameters must match those of the wb_bayer_stat instance it connects.
interface wb_bayer_stat_if #(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int PIX_PER_CLK      = 2,
  parameter int SUM_WIDTH        = 32
);
  logic [1:0]                              iv_pattern;
  logic                                    i_fval;
  logic                                    i_lval;
  logic [PIX_PER_CLK*SENSOR_DAT_WIDTH-1:0] iv_pix_data;
  logic                                    o_fval;
  logic                                    o_lval;
  logic [PIX_PER_CLK*SENSOR_DAT_WIDTH-1:0] ov_pix_data;
  logic [PIX_PER_CLK-1:0]                  ov_r_flag;
  logic [PIX_PER_CLK-1:0]                  ov_g_flag;
  logic [PIX_PER_CLK-1:0]                  ov_b_flag;
  logic [SUM_WIDTH-1:0]                    ov_r_sum;
  logic [SUM_WIDTH-1:0]                    ov_g_sum;
  logic [SUM_WIDTH-1:0]                    ov_b_sum;
  logic                                    o_sum_valid;
  logic                                    o_sum_ovf;

  // Block side: consumes the raw stream, produces tags and statistics.
  modport slave (
    input  iv_pattern, i_fval, i_lval, iv_pix_data,
    output o_fval, o_lval, ov_pix_data, ov_r_flag, ov_g_flag, ov_b_flag,
    output ov_r_sum, ov_g_sum, ov_b_sum, o_sum_valid, o_sum_ovf
  );

  // Source/controller side.
  modport master (
    output iv_pattern, i_fval, i_lval, iv_pix_data,
    input  o_fval, o_lval, ov_pix_data, ov_r_flag, ov_g_flag, ov_b_flag,
    input  ov_r_sum, ov_g_sum, ov_b_sum, o_sum_valid, o_sum_ovf
  );
endinterface

// File: rtl/wb_bayer_stat.sv
// wb_bayer_stat
// Purpose : tags each pixel lane as R, G or B from a Bayer pattern latched at
//           frame start, forwards the stream one clock later, and accumulates
//           saturating per-channel sums that are reported once per frame.
// Ports   : clk      - pixel clock
//           reset_n  - asynchronous active-low reset
//           bus      - wb_bayer_stat_if.slave (stream in/out, flags, sums)
// Lane k of a pixel word sits at bits [k*SENSOR_DAT_WIDTH +: SENSOR_DAT_WIDTH];
// lane 0 is the leftmost pixel on the line.
module wb_bayer_stat #(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int PIX_PER_CLK      = 2,
  parameter int SUM_WIDTH        = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  wb_bayer_stat_if.slave bus
);
  localparam int PW = PIX_PER_CLK * SENSOR_DAT_WIDTH;
  localparam int AW = SUM_WIDTH + 3;

  typedef enum logic [1:0] {
    PAT_GR = 2'd0,
    PAT_RG = 2'd1,
    PAT_GB = 2'd2,
    PAT_BG = 2'd3
  } pattern_e;

  pattern_e                          pattern_q, pattern_d;
  logic [1:0]                        patBits;
  logic                              fvalDly_q, fvalDly2_q, lvalDly_q;
  logic [PW-1:0]                     pixDly_q;
  logic                              seenLow_q, seenLow_d;
  logic                              armed_q, armed_d;
  logic                              lineParity_q, lineParity_d;
  logic                              colParity_q, colParity_d;
  logic [PIX_PER_CLK-1:0]            laneCol;
  logic                              rise, trigger, accEn, isGreen;
  logic [2:0][PIX_PER_CLK-1:0]       flag_q, flag_d;
  logic [2:0][SUM_WIDTH-1:0]         work_q, work_d;
  logic                              ovfWork_q, ovfWork_d;
  logic [2:0][SUM_WIDTH-1:0]         sum_q;
  logic                              sumOvf_q, sumValid_q;
  logic [AW-1:0]                     acc;

  // Frame-start, report and accumulate qualifiers. A frame only counts as
  // started once i_fval has been seen low, so a reset released in the middle
  // of a frame cannot mistake the ongoing frame for a fresh rising edge.
  always_comb begin
    rise      = bus.i_fval && !fvalDly_q && seenLow_q;
    trigger   = !fvalDly_q && fvalDly2_q && armed_q;
    accEn     = fvalDly_q && lvalDly_q && armed_q;
    seenLow_d = seenLow_q || !bus.i_fval;
    armed_d   = rise ? 1'b1 : (trigger ? 1'b0 : armed_q);
    pattern_d = rise ? pattern_e'(bus.iv_pattern) : pattern_q;
  end

  // Line parity restarts with every frame and advances at each line end;
  // the single-lane column toggle restarts with every line.
  always_comb begin
    lineParity_d = lineParity_q;
    if (!bus.i_fval) begin
      lineParity_d = 1'b0;
    end else if (!bus.i_lval && lvalDly_q) begin
      lineParity_d = !lineParity_q;
    end
    colParity_d = bus.i_lval ? !colParity_q : 1'b0;
  end

  // Colour decode. On the frame's first cycle the pattern register has not
  // been loaded yet, so the incoming pattern is used directly. Green sits
  // where line^column matches bit 0 of the pattern code; the non-green site
  // is red on the line selected by bit 1 and blue on the other line.
  always_comb begin
    patBits = rise ? bus.iv_pattern : pattern_q;
    flag_d  = '0;
    laneCol = '0;
    isGreen = 1'b0;
    for (int k = 0; k < PIX_PER_CLK; k++) begin
      laneCol[k] = (PIX_PER_CLK == 1) ? colParity_q : 1'(k % 2);
      isGreen    = ((lineParity_q ^ laneCol[k]) == patBits[0]);
      if (bus.i_fval && bus.i_lval) begin
        flag_d[0][k] = !isGreen && (lineParity_q == patBits[1]);
        flag_d[1][k] = isGreen;
        flag_d[2][k] = !isGreen && (lineParity_q != patBits[1]);
      end
    end
  end

  // Saturating accumulation of the delayed stream into the channel picked by
  // each lane's flag. Any set bit above SUM_WIDTH means the sum overflowed;
  // the sum then pins at all-ones, which keeps it clamped for the rest of the
  // frame. The frame-start clear wins over everything else.
  always_comb begin
    work_d    = work_q;
    ovfWork_d = ovfWork_q;
    acc       = '0;
    for (int c = 0; c < 3; c++) begin
      acc = {3'b000, work_q[c]};
      for (int k = 0; k < PIX_PER_CLK; k++) begin
        if (accEn && flag_q[c][k]) begin
          acc = acc + AW'(pixDly_q[k*SENSOR_DAT_WIDTH +: SENSOR_DAT_WIDTH]);
        end
      end
      if (acc[AW-1:SUM_WIDTH] != '0) begin
        work_d[c] = '1;
        ovfWork_d = 1'b1;
      end else begin
        work_d[c] = acc[SUM_WIDTH-1:0];
      end
    end
    if (rise) begin
      work_d    = '0;
      ovfWork_d = 1'b0;
    end
  end

  // All state. The report copies the working sums as they stand in the
  // trigger cycle, so a frame-start clear on the same edge cannot corrupt it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q    <= PAT_GR;
      fvalDly_q    <= 1'b0;
      fvalDly2_q   <= 1'b0;
      lvalDly_q    <= 1'b0;
      pixDly_q     <= '0;
      seenLow_q    <= 1'b0;
      armed_q      <= 1'b0;
      lineParity_q <= 1'b0;
      colParity_q  <= 1'b0;
      flag_q       <= '0;
      work_q       <= '0;
      ovfWork_q    <= 1'b0;
      sum_q        <= '0;
      sumOvf_q     <= 1'b0;
      sumValid_q   <= 1'b0;
    end else begin
      pattern_q    <= pattern_d;
      fvalDly_q    <= bus.i_fval;
      fvalDly2_q   <= fvalDly_q;
      lvalDly_q    <= bus.i_lval;
      pixDly_q     <= bus.iv_pix_data;
      seenLow_q    <= seenLow_d;
      armed_q      <= armed_d;
      lineParity_q <= lineParity_d;
      colParity_q  <= colParity_d;
      flag_q       <= flag_d;
      work_q       <= work_d;
      ovfWork_q    <= ovfWork_d;
      sumValid_q   <= trigger;
      if (trigger) begin
        sum_q    <= work_q;
        sumOvf_q <= ovfWork_q;
      end
    end
  end

  assign bus.o_fval      = fvalDly_q;
  assign bus.o_lval      = lvalDly_q;
  assign bus.ov_pix_data = pixDly_q;
  assign bus.ov_r_flag   = flag_q[0];
  assign bus.ov_g_flag   = flag_q[1];
  assign bus.ov_b_flag   = flag_q[2];
  assign bus.ov_r_sum    = sum_q[0];
  assign bus.ov_g_sum    = sum_q[1];
  assign bus.ov_b_sum    = sum_q[2];
  assign bus.o_sum_valid = sumValid_q;
  assign bus.o_sum_ovf   = sumOvf_q;
endmodule

// File: tb/tb_wb_bayer_stat.sv
// tb_wb_bayer_stat
// Purpose : self-checking bench for wb_bayer_stat. Three instances share one
//           stimulus: sel 0 = 1 pixel/clk, 32-bit sums; sel 1 = 2 pixels/clk,
//           32-bit sums; sel 2 = 1 pixel/clk, 8-bit sums. Only the selected
//           instance sees frame valid; its outputs are muxed onto obs* signals.
module tb_wb_bayer_stat;
  localparam int W = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  pattern;
  logic        fval, lval;
  logic [19:0] pix;
  int          sel;

  always #5 clk = ~clk;

  wb_bayer_stat_if #(.SENSOR_DAT_WIDTH(10), .PIX_PER_CLK(1), .SUM_WIDTH(32)) if1 ();
  wb_bayer_stat_if #(.SENSOR_DAT_WIDTH(10), .PIX_PER_CLK(2), .SUM_WIDTH(32)) if2 ();
  wb_bayer_stat_if #(.SENSOR_DAT_WIDTH(10), .PIX_PER_CLK(1), .SUM_WIDTH(8))  if3 ();

  wb_bayer_stat #(.SENSOR_DAT_WIDTH(10), .PIX_PER_CLK(1), .SUM_WIDTH(32)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  wb_bayer_stat #(.SENSOR_DAT_WIDTH(10), .PIX_PER_CLK(2), .SUM_WIDTH(32)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  wb_bayer_stat #(.SENSOR_DAT_WIDTH(10), .PIX_PER_CLK(1), .SUM_WIDTH(8))  dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));

  // Stimulus fan-out: unselected instances see an idle stream.
  assign if1.iv_pattern  = pattern;
  assign if2.iv_pattern  = pattern;
  assign if3.iv_pattern  = pattern;
  assign if1.i_fval      = (sel == 0) && fval;
  assign if2.i_fval      = (sel == 1) && fval;
  assign if3.i_fval      = (sel == 2) && fval;
  assign if1.i_lval      = lval;
  assign if2.i_lval      = lval;
  assign if3.i_lval      = lval;
  assign if1.iv_pix_data = pix[9:0];
  assign if2.iv_pix_data = pix;
  assign if3.iv_pix_data = pix[9:0];

  logic        obsFval, obsLval, obsValid, obsOvf;
  logic [19:0] obsPix;
  logic [1:0]  obsRFlag, obsGFlag, obsBFlag;
  logic [31:0] obsRSum, obsGSum, obsBSum;

  // Observation mux for the selected instance, zero-extended to common widths.
  always_comb begin
    obsFval = 1'b0; obsLval = 1'b0; obsValid = 1'b0; obsOvf = 1'b0;
    obsPix = '0; obsRFlag = '0; obsGFlag = '0; obsBFlag = '0;
    obsRSum = '0; obsGSum = '0; obsBSum = '0;
    case (sel)
      0: begin
        obsFval = if1.o_fval; obsLval = if1.o_lval; obsPix = {10'd0, if1.ov_pix_data};
        obsRFlag = {1'b0, if1.ov_r_flag}; obsGFlag = {1'b0, if1.ov_g_flag}; obsBFlag = {1'b0, if1.ov_b_flag};
        obsRSum = if1.ov_r_sum; obsGSum = if1.ov_g_sum; obsBSum = if1.ov_b_sum;
        obsValid = if1.o_sum_valid; obsOvf = if1.o_sum_ovf;
      end
      1: begin
        obsFval = if2.o_fval; obsLval = if2.o_lval; obsPix = if2.ov_pix_data;
        obsRFlag = if2.ov_r_flag; obsGFlag = if2.ov_g_flag; obsBFlag = if2.ov_b_flag;
        obsRSum = if2.ov_r_sum; obsGSum = if2.ov_g_sum; obsBSum = if2.ov_b_sum;
        obsValid = if2.o_sum_valid; obsOvf = if2.o_sum_ovf;
      end
      default: begin
        obsFval = if3.o_fval; obsLval = if3.o_lval; obsPix = {10'd0, if3.ov_pix_data};
        obsRFlag = {1'b0, if3.ov_r_flag}; obsGFlag = {1'b0, if3.ov_g_flag}; obsBFlag = {1'b0, if3.ov_b_flag};
        obsRSum = {24'd0, if3.ov_r_sum}; obsGSum = {24'd0, if3.ov_g_sum}; obsBSum = {24'd0, if3.ov_b_sum};
        obsValid = if3.o_sum_valid; obsOvf = if3.o_sum_ovf;
      end
    endcase
  end

  typedef struct {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
    logic        ovf;
  } report_t;

  report_t    expQ[$];
  logic [2:0] expLog[$], gotLog[$];
  logic [9:0] pixExp[$], pixGot[$];
  int         nCompared = 0;
  int         nFail = 0;

  // Bayer colour table [pattern][line parity][column parity]: 0=R 1=G 2=B.
  int colourTbl [4][2][2] = '{
    '{'{1, 0}, '{2, 1}},
    '{'{0, 1}, '{1, 2}},
    '{'{1, 2}, '{0, 1}},
    '{'{2, 1}, '{1, 0}}
  };

  // Drives one clock of stimulus; returns at the next falling edge, where the
  // registered outputs reflect exactly this cycle's inputs.
  task automatic stepCycle(input logic f, input logic l, input logic [19:0] d);
    fval = f; lval = l; pix = d;
    @(negedge clk);
  endtask

  // Drives one frame, logs the expected/observed tag and data per pixel, and
  // pushes the expected report. Ends with i_fval still high; abortAfter > 0
  // stops mid-line after that many pixels with i_lval still high.
  task automatic driveFrame(input int dsel, input int pat, input int patMid, input int nLines,
                            input int beats, input int base, input int step,
                            input int abortAfter, input bit expectReport);
    int          ppc = (dsel == 1) ? 2 : 1;
    longint      maxSum = (dsel == 2) ? 64'd255 : 64'hFFFF_FFFF;
    longint      acc[3] = '{0, 0, 0};
    int          idx = 0;
    int          v, c;
    bit          aborted = 0;
    logic [19:0] d;
    report_t     e;
    sel = dsel;
    expLog.delete(); gotLog.delete(); pixExp.delete(); pixGot.delete();
    pattern = 2'(pat);
    stepCycle(0, 0, 0); stepCycle(0, 0, 0); stepCycle(1, 0, 0);
    for (int ln = 0; ln < nLines && !aborted; ln++) begin
      for (int bt = 0; bt < beats && !aborted; bt++) begin
        d = '0;
        for (int k = 0; k < ppc; k++) begin
          v = (base + step * idx) & 1023;
          d[k*W +: W] = 10'(v);
          c = colourTbl[pat][ln % 2][(bt * ppc + k) % 2];
          acc[c] += longint'(v);
          expLog.push_back(3'b100 >> c);
          pixExp.push_back(10'(v));
          idx++;
        end
        stepCycle(1, 1, d);
        for (int k = 0; k < ppc; k++) begin
          gotLog.push_back({obsRFlag[k], obsGFlag[k], obsBFlag[k]});
          pixGot.push_back(obsPix[k*W +: W]);
        end
        if (patMid >= 0) pattern = 2'(patMid);
        if (abortAfter != 0 && idx >= abortAfter) aborted = 1;
      end
      if (!aborted) begin
        stepCycle(1, 0, 0); stepCycle(1, 0, 0);
      end
    end
    if (expectReport) begin
      e.r   = 32'((acc[0] > maxSum) ? maxSum : acc[0]);
      e.g   = 32'((acc[1] > maxSum) ? maxSum : acc[1]);
      e.b   = 32'((acc[2] > maxSum) ? maxSum : acc[2]);
      e.ovf = (acc[0] > maxSum) || (acc[1] > maxSum) || (acc[2] > maxSum);
      expQ.push_back(e);
    end
  endtask

  // Drops i_fval and waits, bounded, for o_sum_valid; cnt counts clocks from
  // the cycle in which i_fval went low.
  task automatic waitReport(output bit seen, output int cnt);
    stepCycle(0, 0, 0);
    cnt = 1;
    while (!obsValid && cnt < 12) begin
      stepCycle(0, 0, 0);
      cnt++;
    end
    seen = obsValid;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      nCompared++;
      if ({obsFval, obsLval, obsPix, obsRFlag, obsGFlag, obsBFlag, obsRSum, obsGSum, obsBSum, obsValid, obsOvf} !== '0) begin
        nFail++;
        $display("[TB] FAIL reset_outputs dut%0d: got sums r=%0d g=%0d b=%0d valid=%0b fval=%0b, required all 0",
                 s, obsRSum, obsGSum, obsBSum, obsValid, obsFval);
      end
    end
    sel = 0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ppc1_gr();
    bit seen; int cnt; report_t e;
    driveFrame(0, 0, -1, 2, 4, 1, 1, 0, 1);
    for (int i = 0; i < gotLog.size(); i++) begin
      nCompared++;
      if (gotLog[i] !== expLog[i] || pixGot[i] !== pixExp[i]) begin
        nFail++;
        $display("[TB] FAIL ppc1_gr_lane pixel %0d: got rgb=%b data=%0d, required rgb=%b data=%0d", i, gotLog[i], pixGot[i], expLog[i], pixExp[i]);
      end
    end
    waitReport(seen, cnt);
    e = expQ.pop_front();
    nCompared++;
    if (!seen || cnt != 2) begin
      nFail++;
      $display("[TB] FAIL ppc1_gr_timing: valid=%0b after %0d clocks, required 1 after 2", seen, cnt);
    end
    nCompared++;
    if ({obsRSum, obsGSum, obsBSum, obsOvf} !== {e.r, e.g, e.b, e.ovf}) begin
      nFail++;
      $display("[TB] FAIL ppc1_gr_sums: got r=%0d g=%0d b=%0d ovf=%0b, required r=%0d g=%0d b=%0d ovf=%0b",
               obsRSum, obsGSum, obsBSum, obsOvf, e.r, e.g, e.b, e.ovf);
    end
    stepCycle(0, 0, 0);
    nCompared++;
    if ({obsValid, obsRSum, obsGSum, obsBSum} !== {1'b0, e.r, e.g, e.b}) begin
      nFail++;
      $display("[TB] FAIL ppc1_gr_pulse_hold: got valid=%0b r=%0d g=%0d b=%0d, required valid=0 r=%0d g=%0d b=%0d",
               obsValid, obsRSum, obsGSum, obsBSum, e.r, e.g, e.b);
    end
  endtask

  task automatic test_ppc2_bg();
    bit seen; int cnt; report_t e;
    driveFrame(1, 3, -1, 2, 2, 1, 1, 0, 1);
    for (int i = 0; i < gotLog.size(); i++) begin
      nCompared++;
      if (gotLog[i] !== expLog[i] || pixGot[i] !== pixExp[i]) begin
        nFail++;
        $display("[TB] FAIL ppc2_bg_lane pixel %0d: got rgb=%b data=%0d, required rgb=%b data=%0d", i, gotLog[i], pixGot[i], expLog[i], pixExp[i]);
      end
    end
    waitReport(seen, cnt);
    e = expQ.pop_front();
    nCompared++;
    if (!seen || cnt != 2 || {obsRSum, obsGSum, obsBSum, obsOvf} !== {e.r, e.g, e.b, e.ovf}) begin
      nFail++;
      $display("[TB] FAIL ppc2_bg_report: valid=%0b at %0d r=%0d g=%0d b=%0d ovf=%0b, required valid at 2 r=%0d g=%0d b=%0d ovf=%0b",
               seen, cnt, obsRSum, obsGSum, obsBSum, obsOvf, e.r, e.g, e.b, e.ovf);
    end
  endtask

  task automatic test_saturation();
    bit seen; int cnt; report_t e;
    driveFrame(2, 0, -1, 1, 4, 1023, 0, 0, 1);
    waitReport(seen, cnt);
    e = expQ.pop_front();
    nCompared++;
    if (!seen || {obsRSum, obsGSum, obsBSum, obsOvf} !== {e.r, e.g, e.b, e.ovf}) begin
      nFail++;
      $display("[TB] FAIL sat_clamp: valid=%0b r=%0d g=%0d b=%0d ovf=%0b, required r=%0d g=%0d b=%0d ovf=%0b",
               seen, obsRSum, obsGSum, obsBSum, obsOvf, e.r, e.g, e.b, e.ovf);
    end
    driveFrame(2, 0, -1, 1, 4, 0, 0, 0, 1);
    waitReport(seen, cnt);
    e = expQ.pop_front();
    nCompared++;
    if (!seen || {obsRSum, obsGSum, obsBSum, obsOvf} !== {e.r, e.g, e.b, e.ovf}) begin
      nFail++;
      $display("[TB] FAIL sat_recover: valid=%0b r=%0d g=%0d b=%0d ovf=%0b, required r=%0d g=%0d b=%0d ovf=%0b",
               seen, obsRSum, obsGSum, obsBSum, obsOvf, e.r, e.g, e.b, e.ovf);
    end
  endtask

  task automatic test_pattern_latch();
    bit seen; int cnt; report_t e;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) driveFrame(0, 0, 1, 2, 4, 1, 1, 0, 1);
      else        driveFrame(0, 1, -1, 2, 4, 1, 1, 0, 1);
      for (int i = 0; i < gotLog.size(); i++) begin
        nCompared++;
        if (gotLog[i] !== expLog[i]) begin
          nFail++;
          $display("[TB] FAIL pattern_latch frame %0d pixel %0d: got rgb=%b, required rgb=%b", f, i, gotLog[i], expLog[i]);
        end
      end
      waitReport(seen, cnt);
      e = expQ.pop_front();
      nCompared++;
      if (!seen || {obsRSum, obsGSum, obsBSum, obsOvf} !== {e.r, e.g, e.b, e.ovf}) begin
        nFail++;
        $display("[TB] FAIL pattern_latch_sums frame %0d: valid=%0b r=%0d g=%0d b=%0d, required r=%0d g=%0d b=%0d",
                 f, seen, obsRSum, obsGSum, obsBSum, e.r, e.g, e.b);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit seen; int cnt; report_t e;
    sel = 0;
    pattern = 2'd0;
    stepCycle(0, 0, 0); stepCycle(0, 0, 0); stepCycle(1, 0, 0);
    stepCycle(1, 1, 20'd5); stepCycle(1, 1, 20'd6);
    #2 reset_n = 1'b0;
    #1;
    nCompared++;
    if ({obsFval, obsLval, obsPix, obsRFlag, obsGFlag, obsBFlag, obsRSum, obsGSum, obsBSum, obsValid, obsOvf} !== '0) begin
      nFail++;
      $display("[TB] FAIL midframe_reset_clear: got fval=%0b lval=%0b data=%0d r=%0d g=%0d b=%0d, required all 0",
               obsFval, obsLval, obsPix, obsRSum, obsGSum, obsBSum);
    end
    @(negedge clk);
    reset_n = 1'b1;
    stepCycle(1, 1, 20'd7); stepCycle(1, 1, 20'd8); stepCycle(1, 0, 0);
    waitReport(seen, cnt);
    nCompared++;
    if (seen !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL midframe_reset_no_report: got valid=%0b after %0d clocks, required 0", seen, cnt);
    end
    driveFrame(0, 0, -1, 2, 4, 1, 1, 0, 1);
    waitReport(seen, cnt);
    e = expQ.pop_front();
    nCompared++;
    if (!seen || cnt != 2 || {obsRSum, obsGSum, obsBSum, obsOvf} !== {e.r, e.g, e.b, e.ovf}) begin
      nFail++;
      $display("[TB] FAIL midframe_reset_next: valid=%0b at %0d r=%0d g=%0d b=%0d, required valid at 2 r=%0d g=%0d b=%0d",
               seen, cnt, obsRSum, obsGSum, obsBSum, e.r, e.g, e.b);
    end
  endtask

  task automatic test_abort();
    bit seen; int cnt; report_t e;
    driveFrame(0, 0, -1, 2, 4, 10, 10, 3, 1);
    waitReport(seen, cnt);
    e = expQ.pop_front();
    nCompared++;
    if (!seen || cnt != 2 || {obsRSum, obsGSum, obsBSum, obsOvf} !== {e.r, e.g, e.b, e.ovf}) begin
      nFail++;
      $display("[TB] FAIL abort_report: valid=%0b at %0d r=%0d g=%0d b=%0d, required valid at 2 r=%0d g=%0d b=%0d",
               seen, cnt, obsRSum, obsGSum, obsBSum, e.r, e.g, e.b);
    end
    driveFrame(0, 0, -1, 2, 4, 1, 1, 0, 1);
    for (int i = 0; i < gotLog.size(); i++) begin
      nCompared++;
      if (gotLog[i] !== expLog[i]) begin
        nFail++;
        $display("[TB] FAIL abort_next_parity pixel %0d: got rgb=%b, required rgb=%b", i, gotLog[i], expLog[i]);
      end
    end
    waitReport(seen, cnt);
    e = expQ.pop_front();
    nCompared++;
    if (!seen || {obsRSum, obsGSum, obsBSum, obsOvf} !== {e.r, e.g, e.b, e.ovf}) begin
      nFail++;
      $display("[TB] FAIL abort_next_sums: valid=%0b r=%0d g=%0d b=%0d, required r=%0d g=%0d b=%0d",
               seen, obsRSum, obsGSum, obsBSum, e.r, e.g, e.b);
    end
  endtask

  // Runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    sel = 0; fval = 1'b0; lval = 1'b0; pix = '0; pattern = 2'd0;
    test_reset();
    test_ppc1_gr();
    test_ppc2_bg();
    test_saturation();
    test_pattern_latch();
    test_reset_midframe();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end
endmodule
